// File: rtl/bfu_r2_pipe.sv
// Radix-2 DIT butterfly, 3-stage valid/ready pipeline: x0 = a + b*tw, x1 = a - b*tw.
// Build option BFU_SAT_EN: clamp out-of-range results instead of wrapping (ovf is flagged either way).
module bfu_r2_pipe #(
  parameter int DW      = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = TW_W - 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   in_a,
  input  logic [2*DW-1:0]   in_b,
  input  logic [2*TW_W-1:0] in_tw,
  input  logic              in_scale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_x0,
  output logic [2*DW-1:0]   out_x1,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int MW = DW + TW_W;
  localparam int PW = DW + TW_W + 1;
  localparam int SW = DW + 2;

  localparam logic signed [PW-1:0] RND   = PW'(1) << (TW_FRAC - 1);
  localparam logic signed [SW-1:0] ONE_S = SW'(1);
  localparam logic signed [SW-1:0] MAXV  = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV  = SW'(-(2 ** (DW - 1)));

  logic en;
  logic v1, v2, v3;

  logic signed [DW-1:0]   a1_re, a1_im, b1_re, b1_im;
  logic signed [TW_W-1:0] tw1_re, tw1_im;
  logic                   sc1;

  logic signed [DW-1:0]   a2_re, a2_im;
  logic signed [PW-1:0]   pr2, pi2;
  logic                   sc2;

  logic [2*DW-1:0] x0_q, x1_q;
  logic            ovf_q;

  // A full output register that is not being taken freezes the whole pipe.
  assign en        = ~v3 | out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign out_x0    = x0_q;
  assign out_x1    = x1_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      a1_re  <= '0;
      a1_im  <= '0;
      b1_re  <= '0;
      b1_im  <= '0;
      tw1_re <= '0;
      tw1_im <= '0;
      sc1    <= 1'b0;
    end else if (en) begin
      v1     <= in_valid;
      a1_re  <= in_a[DW-1:0];
      a1_im  <= in_a[2*DW-1:DW];
      b1_re  <= in_b[DW-1:0];
      b1_im  <= in_b[2*DW-1:DW];
      tw1_re <= in_tw[TW_W-1:0];
      tw1_im <= in_tw[2*TW_W-1:TW_W];
      sc1    <= in_scale;
    end
  end

  logic signed [MW-1:0] bre_x, bim_x, wre_x, wim_x;
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0] pr_c, pi_c;

  always_comb begin
    bre_x = MW'(b1_re);
    bim_x = MW'(b1_im);
    wre_x = MW'(tw1_re);
    wim_x = MW'(tw1_im);
    m_rr  = bre_x * wre_x;
    m_ii  = bim_x * wim_x;
    m_ri  = bre_x * wim_x;
    m_ir  = bim_x * wre_x;
    pr_c  = PW'(m_rr) - PW'(m_ii);
    pi_c  = PW'(m_ri) + PW'(m_ir);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2    <= 1'b0;
      a2_re <= '0;
      a2_im <= '0;
      pr2   <= '0;
      pi2   <= '0;
      sc2   <= 1'b0;
    end else if (en) begin
      v2    <= v1;
      a2_re <= a1_re;
      a2_im <= a1_im;
      pr2   <= pr_c;
      pi2   <= pi_c;
      sc2   <= sc1;
    end
  end

  // Returns {out_of_range, narrowed value}; the range test uses the full-precision sum.
  function automatic logic [DW:0] narrow(input logic signed [SW-1:0] s_in, input logic sc);
    logic signed [SW-1:0] s;
    logic                 hi, lo;
    logic [DW-1:0]        v;
    s = s_in;
    if (sc) begin
      s = s + ONE_S;
      s = s >>> 1;
    end
    hi = (s > MAXV);
    lo = (s < MINV);
`ifdef BFU_SAT_EN
    if (hi)      v = MAXV[DW-1:0];
    else if (lo) v = MINV[DW-1:0];
    else         v = s[DW-1:0];
`else
    v = s[DW-1:0];
`endif
    return {hi | lo, v};
  endfunction

  logic signed [PW-1:0] pr_rnd, pi_rnd, pr_sh, pi_sh;
  logic signed [SW-1:0] p_re, p_im, a_re_x, a_im_x;
  logic signed [SW-1:0] s0_re, s0_im, s1_re, s1_im;
  logic [DW:0]          n0_re, n0_im, n1_re, n1_im;
  logic                 ovf_any;

  always_comb begin
    pr_rnd  = pr2 + RND;
    pi_rnd  = pi2 + RND;
    pr_sh   = pr_rnd >>> TW_FRAC;
    pi_sh   = pi_rnd >>> TW_FRAC;
    p_re    = SW'(pr_sh);
    p_im    = SW'(pi_sh);
    a_re_x  = SW'(a2_re);
    a_im_x  = SW'(a2_im);
    s0_re   = a_re_x + p_re;
    s0_im   = a_im_x + p_im;
    s1_re   = a_re_x - p_re;
    s1_im   = a_im_x - p_im;
    n0_re   = narrow(s0_re, sc2);
    n0_im   = narrow(s0_im, sc2);
    n1_re   = narrow(s1_re, sc2);
    n1_im   = narrow(s1_im, sc2);
    ovf_any = n0_re[DW] | n0_im[DW] | n1_re[DW] | n1_im[DW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3   <= 1'b0;
      x0_q <= '0;
      x1_q <= '0;
    end else if (en) begin
      v3   <= v2;
      x0_q <= {n0_im[DW-1:0], n0_re[DW-1:0]};
      x1_q <= {n1_im[DW-1:0], n1_re[DW-1:0]};
    end
  end

  // Flag is raised as a valid beat is loaded into the output register; a set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | (en & v2 & ovf_any);
    end
  end

endmodule
